rpsc_fault_qual: RTL and testbench
==================================

RPSC_FAULT_QUAL -- requirements
Module: rpsc_fault_qual

Interface
REQ-001 Parameter FILTER_CNT, default 16: number of consecutive sampled cycles needed to change a qualified level; legal range 2..255.
REQ-002 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port fault_raw  input  8  unsynchronized fault lines. Bit map: 0 G1_PS_Fault, 1 G2_PS_Fault, 2 Temp_DR_AMP, 3 AN_PS_Fault, 4 AN_PS_Over_Current, 5 I_G1_High, 6 G1_PS_Over_Temp, 7 G2_PS_Internal_Fault; 1 = fault.
REQ-005 Port fault_q  output  8  debounced fault levels; these feed the CARD9 fault inputs, same bit map.
REQ-006 Port fault_rise  output  8  one-cycle pulse per bit when fault_q bit goes 0->1.
REQ-007 Port fault_any  output  1  OR of fault_q.
REQ-008 Port fo_clr  input  1  synchronous clear of the first-out capture.
REQ-009 Port fo_valid  output  1  first-out capture holds a channel.
REQ-010 Port fo_idx  output  3  index of the first channel to qualify.

Function
REQ-011 Each fault_raw bit SHALL pass through a 2-flop synchronizer (s1, s2) before any use.
REQ-012 Each channel SHALL hold a counter cnt, width ceil(log2(FILTER_CNT)).
REQ-013 Each edge with s2 == fault_q SHALL clear cnt to 0.
REQ-014 Each edge with s2 != fault_q and cnt < FILTER_CNT-1 SHALL increment cnt.
REQ-015 Each edge with s2 != fault_q and cnt == FILTER_CNT-1 SHALL set fault_q = s2 and clear cnt.
REQ-016 Rise and fall SHALL be filtered symmetrically.
REQ-017 A raw level held stable SHALL appear on fault_q exactly FILTER_CNT+2 edges after it is first sampled.
REQ-018 A raw excursion shorter than FILTER_CNT synchronized cycles SHALL leave fault_q unchanged; a single opposite-level sample restarts the count.
REQ-019 fault_rise[i] SHALL be registered and high for exactly the one cycle after the edge at which fault_q[i] goes 0->1; there is no pulse on 1->0.
REQ-020 fault_any SHALL be combinational from fault_q (no added latency).
REQ-021 Channels SHALL be fully independent; simultaneous transitions on any subset SHALL all be honoured in the same cycle.
REQ-022 First-out: when fo_valid == 0 and any fault_rise bit is set, the edge SHALL load fo_idx with the lowest set index and set fo_valid.
REQ-023 While fo_valid == 1, later rises SHALL NOT alter fo_idx.
REQ-024 fo_clr SHALL clear fo_valid and fo_idx to 0 on the next edge.
REQ-025 If fo_clr and a fault_rise bit are both set on the same edge, the capture SHALL win: fo_valid = 1, fo_idx = lowest rising index.
REQ-026 fo_clr SHALL NOT affect fault_q, fault_rise or the counters.

Reset
REQ-027 Asserting reset SHALL immediately set s1, s2, cnt, fault_q, fault_rise, fo_valid and fo_idx to 0.
REQ-028 Reset mid-count SHALL discard the partial count.
REQ-029 After release, a fault_raw bit already high SHALL qualify FILTER_CNT+2 edges later.
REQ-030 Reset SHALL be asserted asynchronously and released synchronously to clk by the system.

Configuration
REQ-031 Macro RPSC_FAULT_FIRST_OUT_EN defined: the first-out logic of REQ-022..REQ-025 SHALL be present.
REQ-032 Macro RPSC_FAULT_FIRST_OUT_EN undefined: fo_valid and fo_idx SHALL be tied to 0, fo_clr SHALL be ignored, no first-out flops SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-033 FILTER_CNT=4; fault_raw[0] 0->1 before edge 1, held -> fault_q[0] rises at edge 6; fault_rise[0] = 1 for one cycle; fault_any = 1.
REQ-034 FILTER_CNT=4; fault_raw[3] high for 3 cycles, then low -> fault_q stays 8'h00; no fault_rise.
REQ-035 FILTER_CNT=4; fault_q[2] = 1, then fault_raw[2] low for 3 cycles, high 1 cycle, low held -> fall occurs 4 synchronized low cycles after the high sample, not earlier.
REQ-036 RPSC_FAULT_FIRST_OUT_EN defined; bits 5 and 1 qualify on the same edge, bit 0 later -> fo_idx = 1, fo_valid = 1; fo_clr pulsed coincident with bit 6 rising -> fo_idx = 6, fo_valid = 1.
REQ-037 Reset asserted mid-count with cnt = 2 on bit 4 and fault_q = 8'h81 -> all outputs 0 at once; after release with raw held, bits 0, 4 and 7 requalify at FILTER_CNT+2 edges.
REQ-038 RPSC_FAULT_FIRST_OUT_EN undefined; run the REQ-036 stimulus -> fo_valid = 0 and fo_idx = 0 throughout; fault_q identical to the defined build.

Source files
------------

// File: rtl/rpsc_fault_qual_if.sv
// Fault qualifier bus: raw fault lines in, debounced levels, rise pulses and
// first-out capture out. The module under test takes the slave modport.
interface rpsc_fault_qual_if;
  logic [7:0] fault_raw;
  logic [7:0] fault_q;
  logic [7:0] fault_rise;
  logic       fault_any;
  logic       fo_clr;
  logic       fo_valid;
  logic [2:0] fo_idx;

  modport master (
    output fault_raw, fo_clr,
    input  fault_q, fault_rise, fault_any, fo_valid, fo_idx
  );

  modport slave (
    input  fault_raw, fo_clr,
    output fault_q, fault_rise, fault_any, fo_valid, fo_idx
  );
endinterface

// File: rtl/rpsc_fault_qual.sv
// RPSC fault qualifier: per-channel 2-flop sync plus symmetric debounce filter,
// rise pulses and optional first-out capture (macro RPSC_FAULT_FIRST_OUT_EN).
module rpsc_fault_qual #(
  parameter int unsigned FILTER_CNT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  rpsc_fault_qual_if.slave     bus
);

  localparam int unsigned NCH = 8;
  localparam int unsigned CW  = $clog2(FILTER_CNT);
  localparam int unsigned IW  = 3;

  logic [NCH-1:0] r_s1;
  logic [NCH-1:0] r_s2;
  logic [NCH-1:0] r_q;
  logic [NCH-1:0] r_rise;
  logic [CW-1:0]  r_cnt [NCH];

  // Synchronizer and debounce: the level flips only after FILTER_CNT
  // consecutive synchronized samples disagree with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_q    <= '0;
      r_rise <= '0;
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= bus.fault_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < NCH; i++) begin
        r_rise[i] <= 1'b0;
        if (r_s2[i] == r_q[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(FILTER_CNT - 1)) begin
          r_q[i]    <= r_s2[i];
          r_rise[i] <= r_s2[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign bus.fault_q    = r_q;
  assign bus.fault_rise = r_rise;
  assign bus.fault_any  = |r_q;

`ifdef RPSC_FAULT_FIRST_OUT_EN
  logic          r_fo_valid;
  logic [IW-1:0] r_fo_idx;
  logic [IW-1:0] w_lo_idx;

  // Lowest-numbered channel rising this cycle.
  always_comb begin
    w_lo_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (r_rise[i]) w_lo_idx = IW'(i);
    end
  end

  // A rise coincident with fo_clr re-arms and captures in one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fo_valid <= 1'b0;
      r_fo_idx   <= '0;
    end else if ((|r_rise) && (!r_fo_valid || bus.fo_clr)) begin
      r_fo_valid <= 1'b1;
      r_fo_idx   <= w_lo_idx;
    end else if (bus.fo_clr) begin
      r_fo_valid <= 1'b0;
      r_fo_idx   <= '0;
    end
  end

  assign bus.fo_valid = r_fo_valid;
  assign bus.fo_idx   = r_fo_idx;
`else
  logic w_unused_fo_clr;

  assign w_unused_fo_clr = bus.fo_clr;
  assign bus.fo_valid    = 1'b0;
  assign bus.fo_idx      = '0;
`endif

endmodule

// File: tb/tb_rpsc_fault_qual.sv
// Testbench for rpsc_fault_qual: directed scenarios plus randomized traffic,
// all checked against a sliding-window reference model.
module tb_rpsc_fault_qual;

  localparam int unsigned N = 4;
`ifdef RPSC_FAULT_FIRST_OUT_EN
  localparam bit FO_EN = 1'b1;
`else
  localparam bit FO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  rpsc_fault_qual_if bus ();

  rpsc_fault_qual #(.FILTER_CNT(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] mq, mrise, d0, d1;
  logic       mfv;
  logic [2:0] mfi;
  logic [7:0] win[$];

  wire [20:0] w_dut = {bus.fault_q, bus.fault_rise, bus.fault_any, bus.fo_valid, bus.fo_idx};

  function automatic logic [20:0] exp_vec();
    return {mq, mrise, |mq, FO_EN ? mfv : 1'b0, FO_EN ? mfi : 3'd0};
  endfunction

  task automatic model_reset();
    mq = '0; mrise = '0; d0 = '0; d1 = '0; mfv = 1'b0; mfi = '0;
    win.delete();
    for (int j = 0; j < N; j++) win.push_back(8'h00);
  endtask

  // One clock edge: a channel flips when its last N synchronized samples all
  // disagree with its current level.
  task automatic model_step(input logic [7:0] raw, input logic clr);
    logic [7:0] samp, newq;
    logic       all;
    if ((|mrise) && (!mfv || clr)) begin
      mfv = 1'b1;
      for (int i = 7; i >= 0; i--) if (mrise[i]) mfi = 3'(i);
    end else if (clr) begin
      mfv = 1'b0; mfi = '0;
    end
    samp = d1; d1 = d0; d0 = raw;
    win.push_back(samp);
    if (win.size() > N) void'(win.pop_front());
    newq = mq;
    for (int i = 0; i < 8; i++) begin
      all = 1'b1;
      foreach (win[j]) if (win[j][i] == mq[i]) all = 1'b0;
      if (all) newq[i] = ~mq[i];
    end
    mrise = newq & ~mq;
    mq = newq;
  endtask

  task automatic tick(input logic [7:0] raw, input logic clr);
    bus.fault_raw = raw;
    bus.fo_clr    = clr;
    @(posedge clk);
    model_step(raw, clr);
    #1;
  endtask

  task automatic apply_reset();
    bus.fault_raw = '0;
    bus.fo_clr    = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.fault_raw = 8'hFF;
    bus.fo_clr    = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_run++;
    if (w_dut !== 21'h0) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", w_dut, 21'h0);
    end
    apply_reset();
    n_run++;
    if (w_dut !== exp_vec()) begin
      n_fail++; $display("FAIL reset_release: got %h expected %h", w_dut, exp_vec());
    end
  endtask

  task automatic test_rise();
    logic [2:0] exp3, got3;
    apply_reset();
    for (int e = 1; e <= 9; e++) begin
      tick(8'h01, 1'b0);
      exp3 = {e >= 6, e == 6, e >= 6};
      got3 = {bus.fault_q[0], bus.fault_rise[0], bus.fault_any};
      n_run++;
      if (got3 !== exp3) begin
        n_fail++; $display("FAIL rise_edge%0d: got %b expected %b", e, got3, exp3);
      end
      n_run++;
      if (w_dut !== exp_vec()) begin
        n_fail++; $display("FAIL rise_model%0d: got %h expected %h", e, w_dut, exp_vec());
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    for (int e = 1; e <= 12; e++) begin
      tick((e <= 3) ? 8'h08 : 8'h00, 1'b0);
      n_run++;
      if ({bus.fault_q, bus.fault_rise} !== 16'h0) begin
        n_fail++; $display("FAIL glitch_edge%0d: got %h expected 0000", e, {bus.fault_q, bus.fault_rise});
      end
      n_run++;
      if (w_dut !== exp_vec()) begin
        n_fail++; $display("FAIL glitch_model%0d: got %h expected %h", e, w_dut, exp_vec());
      end
    end
  endtask

  task automatic test_fall();
    apply_reset();
    for (int e = 0; e < 8; e++) tick(8'h04, 1'b0);
    n_run++;
    if (bus.fault_q !== 8'h04) begin
      n_fail++; $display("FAIL fall_setup: got %h expected 04", bus.fault_q);
    end
    for (int e = 0; e < 3; e++) tick(8'h00, 1'b0);
    tick(8'h04, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      tick(8'h00, 1'b0);
      n_run++;
      if (bus.fault_q[2] !== (k < 6)) begin
        n_fail++; $display("FAIL fall_k%0d: got %b expected %b", k, bus.fault_q[2], k < 6);
      end
      n_run++;
      if (w_dut !== exp_vec()) begin
        n_fail++; $display("FAIL fall_model%0d: got %h expected %h", k, w_dut, exp_vec());
      end
    end
  endtask

  task automatic test_first_out();
    logic [3:0] exp_fo;
    apply_reset();
    for (int e = 0; e < 10; e++) tick(8'h22, 1'b0);
    for (int e = 0; e < 10; e++) begin
      tick(8'h23, 1'b0);
      n_run++;
      if (w_dut !== exp_vec()) begin
        n_fail++; $display("FAIL fo_model_a%0d: got %h expected %h", e, w_dut, exp_vec());
      end
    end
    exp_fo = FO_EN ? 4'b1_001 : 4'b0_000;
    n_run++;
    if ({bus.fo_valid, bus.fo_idx} !== exp_fo) begin
      n_fail++; $display("FAIL fo_first: got %b expected %b", {bus.fo_valid, bus.fo_idx}, exp_fo);
    end
    // fo_clr is raised exactly on the edge where bit 6 is pulsing.
    for (int e = 0; e < 10; e++) begin
      tick(8'h63, mrise[6]);
      n_run++;
      if (w_dut !== exp_vec()) begin
        n_fail++; $display("FAIL fo_model_b%0d: got %h expected %h", e, w_dut, exp_vec());
      end
    end
    exp_fo = FO_EN ? 4'b1_110 : 4'b0_000;
    n_run++;
    if ({bus.fault_q, bus.fo_valid, bus.fo_idx} !== {8'h63, exp_fo}) begin
      n_fail++; $display("FAIL fo_clr_rise: got %h expected %h", {bus.fault_q, bus.fo_valid, bus.fo_idx}, {8'h63, exp_fo});
    end
    tick(8'h63, 1'b1);
    tick(8'h63, 1'b0);
    n_run++;
    if ({bus.fault_q, bus.fo_valid, bus.fo_idx} !== {8'h63, 4'b0000}) begin
      n_fail++; $display("FAIL fo_clr_plain: got %h expected %h", {bus.fault_q, bus.fo_valid, bus.fo_idx}, {8'h63, 4'b0000});
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int e = 0; e < 8; e++) tick(8'h81, 1'b0);
    n_run++;
    if (bus.fault_q !== 8'h81) begin
      n_fail++; $display("FAIL rmid_setup: got %h expected 81", bus.fault_q);
    end
    for (int e = 0; e < 4; e++) tick(8'h91, 1'b0);
    #2 reset = 1'b1;
    #1;
    n_run++;
    if (w_dut !== 21'h0) begin
      n_fail++; $display("FAIL rmid_async: got %h expected %h", w_dut, 21'h0);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick(8'h91, 1'b0);
      n_run++;
      if (bus.fault_q !== ((e >= N + 2) ? 8'h91 : 8'h00)) begin
        n_fail++; $display("FAIL rmid_edge%0d: got %h expected %h", e, bus.fault_q, (e >= N + 2) ? 8'h91 : 8'h00);
      end
      n_run++;
      if (w_dut !== exp_vec()) begin
        n_fail++; $display("FAIL rmid_model%0d: got %h expected %h", e, w_dut, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] raw;
    logic       clr;
    apply_reset();
    raw = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 8; i++) if ($urandom_range(7) == 0) raw[i] = ~raw[i];
      clr = ($urandom_range(15) == 0);
      tick(raw, clr);
      n_run++;
      if (w_dut !== exp_vec()) begin
        n_fail++; $display("FAIL random_c%0d: got %h expected %h", c, w_dut, exp_vec());
      end
    end
  endtask

  initial begin
    bus.fault_raw = '0;
    bus.fo_clr    = 1'b0;
    model_reset();
    test_reset();
    test_rise();
    test_glitch();
    test_fall();
    test_first_out();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
